// File: rtl/sprite_pkg.sv
// Purpose: constants and types shared by the sprite ROM arbiter and the pixel layer mux.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sprite_pkg;

    localparam int PIX_W  = 5;
    localparam int ADDR_W = 16;

    localparam logic [PIX_W-1:0] TRANSPARENT_PIX = 5'h15;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [ADDR_W-1:0] sprite_addr_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Purpose: fetcher-facing bundle of the sprite ROM arbiter (requests, grants, pixel responses).
// Latency: none (wires only).
// Backpressure: a fetcher holds req with a stable address until it sees its gnt bit.
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = sprite_pkg::ADDR_W,
    parameter int PIX_W   = sprite_pkg::PIX_W
);
    import sprite_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [PIX_W-1:0]          rsp_pixel;
    logic                      rsp_opaque;

    // Fetcher side.
    modport master (
        output req, req_addr,
        input  gnt, rsp_valid, rsp_pixel, rsp_opaque
    );

    // Arbiter side.
    modport slave (
        input  req, req_addr,
        output gnt, rsp_valid, rsp_pixel, rsp_opaque
    );

endinterface

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// Purpose: round-robin picker; first set req bit scanning from ptr upward, wrapping at NUM_REQ.
// Latency: combinational.
// Backpressure: none; a request simply stays unpicked until its turn comes.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   win_idx,
    output logic               win_vld
);

    logic [PTR_W:0] pos;

    // Walk the NUM_REQ positions starting at ptr; the wrap is explicit so non-power-of-two counts work.
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        win_vld = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_REQ)) begin
                pos = pos - (PTR_W+1)'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_vld && (pos == (PTR_W+1)'(i)) && req[i]) begin
                    win_vld = 1'b1;
                    win_idx = PTR_W'(i);
                    gnt[i]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Purpose: shares one synchronous sprite ROM among NUM_REQ fetchers with round-robin grants.
// Latency: grant in cycle T -> rsp_valid/rsp_pixel in cycle T+ROM_LAT+2.
// Backpressure: one grant per cycle; losers keep req high and wait at most NUM_REQ-1 cycles.
module sprite_rom_arbiter #(
    parameter int                           NUM_REQ     = 4,
    parameter int                           ADDR_W      = sprite_pkg::ADDR_W,
    parameter int                           PIX_W       = sprite_pkg::PIX_W,
    parameter int                           ROM_LAT     = 2,
    parameter logic [sprite_pkg::PIX_W-1:0] TRANSPARENT = sprite_pkg::TRANSPARENT_PIX
) (
    input  logic                Clk,
    input  logic                Reset,
    sprite_rom_arbiter_if.slave bus,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic                rom_en,
    input  logic [PIX_W-1:0]    rom_data
);
    import sprite_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAG_N = ROM_LAT + 1;

    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [ADDR_W-1:0]               rom_addr_q, rom_addr_d;
    logic                            rom_en_q, rom_en_d;
    logic [TAG_N-1:0]                tag_vld_q, tag_vld_d;
    logic [TAG_N-1:0][NUM_REQ-1:0]   tag_id_q, tag_id_d;
    logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
    logic [PIX_W-1:0]                rsp_pixel_q, rsp_pixel_d;

    logic [NUM_REQ-1:0]              pick_gnt;
    logic [PTR_W-1:0]                pick_idx;
    logic                            pick_vld;
    logic [NUM_REQ-1:0]              gnt;
    logic                            grant_vld;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    // Nothing is accepted while Reset is high, since the tag pipeline would discard it anyway.
    assign gnt       = Reset ? '0 : pick_gnt;
    assign grant_vld = ~Reset & pick_vld;

    // Pointer advance past the winner and ROM address/enable issue for the granted request.
    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        rom_en_d   = 1'b0;
        if (grant_vld) begin
            ptr_d    = (pick_idx == PTR_W'(NUM_REQ-1)) ? '0 : pick_idx + PTR_W'(1);
            rom_en_d = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick_idx == PTR_W'(i)) begin
                    rom_addr_d = bus.req_addr[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // Tag shift register: stage 0 lines up with rom_addr, stage ROM_LAT with rom_data.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = grant_vld;
        tag_id_d[0]  = gnt;
        for (int s = 1; s < TAG_N; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    // Capture the ROM word for the aligned tag; pixel holds between responses.
    always_comb begin
        rsp_valid_d = '0;
        rsp_pixel_d = rsp_pixel_q;
        if (tag_vld_q[ROM_LAT]) begin
            rsp_valid_d = tag_id_q[ROM_LAT];
            rsp_pixel_d = rom_data;
        end
    end

    // State registers; reset drops every in-flight tag and restarts the rotation at requester 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q       <= '0;
            rom_addr_q  <= '0;
            rom_en_q    <= 1'b0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_pixel_q <= TRANSPARENT;
        end else begin
            ptr_q       <= ptr_d;
            rom_addr_q  <= rom_addr_d;
            rom_en_q    <= rom_en_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pixel_q <= rsp_pixel_d;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_pixel  = rsp_pixel_q;
    assign bus.rsp_opaque = (|rsp_valid_q) && (rsp_pixel_q != TRANSPARENT);
    assign rom_addr       = rom_addr_q;
    assign rom_en         = rom_en_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Purpose: directed self-checking bench for sprite_rom_arbiter with a 2-cycle ROM model.
// Latency: checks land 4 cycles after each grant at the default ROM_LAT.
// Backpressure: fetchers drop req in the cycle after their grant unless a test holds it.
module tb_sprite_rom_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic [4:0]  rom_data;
    logic [4:0]  rom_d1, rom_d2;

    int checks = 0;
    int errors = 0;

    sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(16), .PIX_W(5)) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ     (4),
        .ADDR_W      (16),
        .PIX_W       (5),
        .ROM_LAT     (2),
        .TRANSPARENT (5'h15)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .bus      (bus.slave),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .rom_data (rom_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [4:0] rom_lookup(input logic [15:0] a);
        if (a == 16'h1234) return 5'h07;
        return a[4:0];
    endfunction

    // Two-register ROM: address seen in cycle C gives data in cycle C+2.
    always @(posedge Clk) begin
        rom_d1 <= rom_lookup(rom_addr);
        rom_d2 <= rom_d1;
    end
    assign rom_data = rom_d2;

    // Start a new cycle: drive inputs just after the edge, then let the comb paths settle.
    task automatic cyc(input logic [3:0] r, input logic rst);
        @(posedge Clk);
        #1;
        bus.req = r;
        Reset   = rst;
        #1;
    endtask

    task automatic apply_reset();
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
    endtask

    task automatic set_addrs(input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] a2, input logic [15:0] a3);
        bus.req_addr = {a3, a2, a1, a0};
    endtask

    task automatic test_reset();
        set_addrs(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
        for (int c = 0; c < 2; c++) begin
            cyc(4'b1111, 1'b1);
            checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
            checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %b exp 0", rom_en); end
            checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", bus.rsp_valid); end
            checks++; if (bus.rsp_pixel !== 5'h15) begin errors++; $display("FAIL reset_rsp_pixel got %h exp 15", bus.rsp_pixel); end
            checks++; if (bus.rsp_opaque !== 1'b0) begin errors++; $display("FAIL reset_rsp_opaque got %b exp 0", bus.rsp_opaque); end
        end
        cyc(4'b1111, 1'b0);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b exp 0001", bus.gnt); end
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_after_rom_en got %b exp 0", rom_en); end
        checks++; if (bus.rsp_pixel !== 5'h15) begin errors++; $display("FAIL reset_after_pixel got %h exp 15", bus.rsp_pixel); end
        cyc(4'b0000, 1'b0);
        checks++; if (rom_en !== 1'b1 || rom_addr !== 16'h0A01) begin errors++; $display("FAIL reset_first_issue got en %b addr %h exp 1 0a01", rom_en, rom_addr); end
        for (int c = 0; c < 5; c++) cyc(4'b0000, 1'b0);
    endtask

    task automatic test_single();
        apply_reset();
        set_addrs(16'h0000, 16'h0000, 16'h1234, 16'h0000);
        cyc(4'b0100, 1'b0);
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", bus.gnt); end
        cyc(4'b0000, 1'b0);
        checks++; if (rom_addr !== 16'h1234 || rom_en !== 1'b1) begin errors++; $display("FAIL single_issue got addr %h en %b exp 1234 1", rom_addr, rom_en); end
        cyc(4'b0000, 1'b0);
        checks++; if (rom_en !== 1'b0 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_t2 got en %b rsp %b exp 0 0000", rom_en, bus.rsp_valid); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp got %b exp 0000", bus.rsp_valid); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got %b exp 0100", bus.rsp_valid); end
        checks++; if (bus.rsp_pixel !== 5'h07) begin errors++; $display("FAIL single_rsp_pixel got %h exp 07", bus.rsp_pixel); end
        checks++; if (bus.rsp_opaque !== 1'b1) begin errors++; $display("FAIL single_rsp_opaque got %b exp 1", bus.rsp_opaque); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_pixel !== 5'h07 || bus.rsp_opaque !== 1'b0) begin
            errors++; $display("FAIL single_after got rsp %b pix %h opq %b exp 0000 07 0", bus.rsp_valid, bus.rsp_pixel, bus.rsp_opaque);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_gnt;
        logic [4:0]  exp_pix;
        logic [15:0] exp_addr;
        apply_reset();
        set_addrs(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
        for (int k = 0; k < 13; k++) begin
            cyc((k < 8) ? 4'b1111 : 4'b0000, 1'b0);
            if (k < 8) begin
                exp_gnt = 4'b0001 << (k % 4);
                checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt cyc %0d got %b exp %b", k, bus.gnt, exp_gnt); end
            end
            if (k >= 1 && k < 9) begin
                exp_addr = 16'h0A01 + 16'((k - 1) % 4);
                checks++; if (rom_addr !== exp_addr || rom_en !== 1'b1) begin errors++; $display("FAIL rr_issue cyc %0d got %h exp %h", k, rom_addr, exp_addr); end
            end
            if (k >= 4 && k < 12) begin
                exp_gnt = 4'b0001 << ((k - 4) % 4);
                exp_pix = 5'(((k - 4) % 4) + 1);
                checks++; if (bus.rsp_valid !== exp_gnt || bus.rsp_pixel !== exp_pix) begin
                    errors++; $display("FAIL rr_rsp cyc %0d got %b/%h exp %b/%h", k, bus.rsp_valid, bus.rsp_pixel, exp_gnt, exp_pix);
                end
            end
            if (k == 12) begin
                checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rr_drain got %b exp 0000", bus.rsp_valid); end
            end
        end
    endtask

    task automatic test_transparency();
        apply_reset();
        set_addrs(16'h0000, 16'h0015, 16'h0000, 16'h0000);
        cyc(4'b0010, 1'b0);
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL transp_gnt got %b exp 0010", bus.gnt); end
        for (int c = 0; c < 4; c++) cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL transp_rsp_valid got %b exp 0010", bus.rsp_valid); end
        checks++; if (bus.rsp_pixel !== 5'h15) begin errors++; $display("FAIL transp_rsp_pixel got %h exp 15", bus.rsp_pixel); end
        checks++; if (bus.rsp_opaque !== 1'b0) begin errors++; $display("FAIL transp_rsp_opaque got %b exp 0", bus.rsp_opaque); end
    endtask

    task automatic test_fairness_skip();
        apply_reset();
        set_addrs(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
        cyc(4'b0010, 1'b0);
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL skip_setup_gnt got %b exp 0010", bus.gnt); end
        cyc(4'b1011, 1'b0);
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL skip_gnt3 got %b exp 1000", bus.gnt); end
        cyc(4'b0001, 1'b0);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL skip_gnt0 got %b exp 0001", bus.gnt); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL skip_idle_gnt got %b exp 0000", bus.gnt); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_pixel !== 5'h02) begin errors++; $display("FAIL skip_rsp_a got %b/%h exp 0010/02", bus.rsp_valid, bus.rsp_pixel); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_pixel !== 5'h04) begin errors++; $display("FAIL skip_rsp_b got %b/%h exp 1000/04", bus.rsp_valid, bus.rsp_pixel); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_pixel !== 5'h01) begin errors++; $display("FAIL skip_rsp_c got %b/%h exp 0001/01", bus.rsp_valid, bus.rsp_pixel); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL skip_no_rsp1 got %b exp 0000", bus.rsp_valid); end
        cyc(4'b0011, 1'b0);
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL skip_ptr1 got %b exp 0010", bus.gnt); end
        for (int c = 0; c < 5; c++) cyc(4'b0000, 1'b0);
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        set_addrs(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
        cyc(4'b0001, 1'b0);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt_t got %b exp 0001", bus.gnt); end
        cyc(4'b0100, 1'b0);
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt_t1 got %b exp 0100", bus.gnt); end
        cyc(4'b1111, 1'b1);
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt_in_reset got %b exp 0000", bus.gnt); end
        cyc(4'b1010, 1'b0);
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_ptr0_gnt got %b exp 0010", bus.gnt); end
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL mid_rom_en got %b exp 0", rom_en); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_t4 got %b exp 0000", bus.rsp_valid); end
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_t5 got %b exp 0000", bus.rsp_valid); end
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_pixel !== 5'h02) begin errors++; $display("FAIL mid_rsp_after got %b/%h exp 0010/02", bus.rsp_valid, bus.rsp_pixel); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b1;
        bus.req      = 4'b1111;
        bus.req_addr = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_transparency();
        test_fairness_skip();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
